// File: rtl/dff_reg_rr_scheduler.sv
// Round-robin front end for one shared WIDTH-bit D/PRE/CLR register.
// It serialises load/preset/clear/read requests from NREQ requesters and returns a per-requester ack with read data.
module dff_reg_rr_scheduler #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                    Clk,
    input  logic                    CLR,
    input  logic [NREQ-1:0]         req,
    input  logic [2*NREQ-1:0]       op,
    input  logic [WIDTH*NREQ-1:0]   wdata,
    input  logic [WIDTH-1:0]        reg_q,
    output logic [WIDTH-1:0]        reg_d,
    output logic                    reg_load,
    output logic                    reg_pre,
    output logic                    reg_clr,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         ack,
    output logic [WIDTH-1:0]        rdata,
    output logic                    busy
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] ACK  = 2'd2;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_PRE  = 2'b01;
    localparam logic [1:0] OP_CLR  = 2'b10;

    logic [1:0]       state_reg;
    logic [IDXW-1:0]  last_reg;
    logic [IDXW-1:0]  win_reg;
    logic [1:0]       op_reg;
    logic [WIDTH-1:0] wdata_reg;
    logic [WIDTH-1:0] rdata_reg;

    logic [1:0]       op_arr    [NREQ];
    logic [WIDTH-1:0] wdata_arr [NREQ];

    logic             pick_valid;
    logic [IDXW-1:0]  pick_idx;
    logic [IDXW-1:0]  cand;

    logic             in_txn;
    logic             in_ack;

    assign in_txn = (state_reg == EXEC) || (state_reg == ACK);
    assign in_ack = (state_reg == ACK);

    // Per-requester views of the flat op/wdata buses plus one-hot grant and ack decode.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
            assign op_arr[gi]    = op[2*gi +: 2];
            assign wdata_arr[gi] = wdata[WIDTH*gi +: WIDTH];
            assign gnt[gi]       = in_txn && (win_reg == IDXW'(gi));
            assign ack[gi]       = in_ack && (win_reg == IDXW'(gi));
        end
    endgenerate

    // Scan from farthest to nearest offset so the nearest set bit after last_reg wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = IDXW'((int'(last_reg) + k) % NREQ);
            if (req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        reg_load = 1'b0;
        reg_pre  = 1'b0;
        reg_clr  = 1'b0;
        reg_d    = '0;
        if (state_reg == EXEC) begin
            case (op_reg)
                OP_LOAD: begin
                    reg_load = 1'b1;
                    reg_d    = wdata_reg;
                end
                OP_PRE:  reg_pre = 1'b1;
                OP_CLR:  reg_clr = 1'b1;
                default: ;
            endcase
        end
    end

    assign busy  = (state_reg != IDLE);
    assign rdata = rdata_reg;

    // Pulses are decoded from state, so reset kills them without waiting for a clock edge.
    always_ff @(posedge Clk or negedge CLR) begin
        if (!CLR) begin
            state_reg <= IDLE;
            last_reg  <= IDXW'(NREQ - 1);
            win_reg   <= '0;
            op_reg    <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pick_valid) begin
                        win_reg   <= pick_idx;
                        last_reg  <= pick_idx;
                        op_reg    <= op_arr[pick_idx];
                        wdata_reg <= wdata_arr[pick_idx];
                        state_reg <= EXEC;
                    end
                end
                EXEC: begin
                    // Samples Q on the same edge the register updates, so this is the pre-update value.
                    rdata_reg <= reg_q;
                    state_reg <= ACK;
                end
                ACK:     state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dff_reg_rr_scheduler.sv
// Bench for dff_reg_rr_scheduler: models the shared register bank and checks each transaction
// against a transaction-level round-robin reference model.
module tb_dff_reg_rr_scheduler;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    typedef struct packed {
        logic [3:0] gnt_e;
        logic [3:0] ack_e;
        logic       load;
        logic       pre;
        logic       clr;
        logic [7:0] d;
        logic       busy_e;
        logic [3:0] gnt_a;
        logic [3:0] ack_a;
        logic       pulses_a;
        logic [7:0] rdata;
        logic       busy_i;
    } obs_t;

    logic        Clk = 1'b0;
    logic        CLR;
    logic [3:0]  req;
    logic [7:0]  op;
    logic [31:0] wdata;
    logic [7:0]  bank_q = 8'h00;
    logic [7:0]  reg_d;
    logic        reg_load;
    logic        reg_pre;
    logic        reg_clr;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic [7:0]  rdata;
    logic        busy;

    int          errors = 0;
    int          checks = 0;
    int          last_m = NREQ - 1;
    logic [7:0]  regm   = 8'h00;
    bit          inv_on = 1'b0;

    always #5 Clk = ~Clk;

    dff_reg_rr_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .Clk      (Clk),
        .CLR      (CLR),
        .req      (req),
        .op       (op),
        .wdata    (wdata),
        .reg_q    (bank_q),
        .reg_d    (reg_d),
        .reg_load (reg_load),
        .reg_pre  (reg_pre),
        .reg_clr  (reg_clr),
        .gnt      (gnt),
        .ack      (ack),
        .rdata    (rdata),
        .busy     (busy)
    );

    // The shared register bank driven by the scheduler's pulses.
    always @(posedge Clk) begin
        if (reg_load)     bank_q <= reg_d;
        else if (reg_pre) bank_q <= 8'hFF;
        else if (reg_clr) bank_q <= 8'h00;
    end

    always @(negedge Clk) begin
        if (inv_on) begin
            checks++;
            if ((int'(reg_load) + int'(reg_pre) + int'(reg_clr)) > 1 ||
                $countones(gnt) > 1 || $countones(ack) > 1) begin
                errors++;
                $display("FAIL invariant: load/pre/clr=%b%b%b gnt=%b ack=%b, required at most one hot each",
                         reg_load, reg_pre, reg_clr, gnt, ack);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    // Reference: pick the first requester after the last served one, apply the op to a model register.
    task automatic model_txn(input logic [3:0] r, input logic [7:0] o, input logic [31:0] wd,
                             output obs_t ex);
        int         w;
        logic [1:0] wop;
        logic [7:0] wdat;
        w = -1;
        for (int k = 1; k <= NREQ; k++)
            if (w < 0 && r[(last_m + k) % NREQ]) w = (last_m + k) % NREQ;
        wop  = o[2*w +: 2];
        wdat = wd[8*w +: 8];
        ex          = '0;
        ex.gnt_e    = 4'b0001 << w;
        ex.load     = (wop == 2'b00);
        ex.pre      = (wop == 2'b01);
        ex.clr      = (wop == 2'b10);
        ex.d        = (wop == 2'b00) ? wdat : 8'h00;
        ex.busy_e   = 1'b1;
        ex.gnt_a    = 4'b0001 << w;
        ex.ack_a    = 4'b0001 << w;
        ex.rdata    = regm;
        case (wop)
            2'b00:   regm = wdat;
            2'b01:   regm = 8'hFF;
            2'b10:   regm = 8'h00;
            default: ;
        endcase
        last_m = w;
    endtask

    // Drives one transaction from an IDLE negedge and samples EXEC, ACK and the following IDLE cycle.
    // drop: 0 keep req, 1 drop during ACK, 2 drop during EXEC.
    task automatic txn(input logic [3:0] r, input logic [7:0] o, input logic [31:0] wd,
                       input int drop, output obs_t ob, output time t_ack);
        req   = r;
        op    = o;
        wdata = wd;
        @(negedge Clk);
        ob.gnt_e  = gnt;
        ob.ack_e  = ack;
        ob.load   = reg_load;
        ob.pre    = reg_pre;
        ob.clr    = reg_clr;
        ob.d      = reg_d;
        ob.busy_e = busy;
        if (drop == 2) req = 4'b0000;
        @(negedge Clk);
        ob.gnt_a    = gnt;
        ob.ack_a    = ack;
        ob.pulses_a = reg_load | reg_pre | reg_clr;
        ob.rdata    = rdata;
        t_ack       = $time;
        if (drop == 1) req = 4'b0000;
        @(negedge Clk);
        ob.busy_i = busy;
    endtask

    task automatic test_reset();
        CLR = 1'b0; req = 4'b0000; op = 8'h00; wdata = 32'h0;
        #1;
        checks++;
        if ({gnt, ack, reg_d, reg_load, reg_pre, reg_clr, rdata, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got gnt=%b ack=%b d=%h lpc=%b%b%b rdata=%h busy=%b, required all 0",
                     gnt, ack, reg_d, reg_load, reg_pre, reg_clr, rdata, busy);
        end
        repeat (2) @(negedge Clk);
        CLR = 1'b1;
        inv_on = 1'b1;
        req = 4'b0001; op = 8'h00; wdata = 32'h0000_005A;
        @(negedge Clk);
        checks++;
        if (reg_load !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_cut_load: reg_load=%b, required 1", reg_load);
        end
        #2 CLR = 1'b0;
        #1;
        checks++;
        if ({reg_load, gnt, busy, reg_d} !== '0) begin
            errors++;
            $display("FAIL reset_cut: reg_load=%b gnt=%b busy=%b d=%h, required all 0",
                     reg_load, gnt, busy, reg_d);
        end
        req = 4'b0000;
        #20;
        @(negedge Clk);
        CLR = 1'b1;
        last_m = NREQ - 1;
        repeat (3) begin
            @(negedge Clk);
            checks++;
            if (busy !== 1'b0 || gnt !== 4'b0 || ack !== 4'b0) begin
                errors++;
                $display("FAIL reset_idle: busy=%b gnt=%b ack=%b, required 0", busy, gnt, ack);
            end
        end
        checks++;
        if (bank_q !== regm) begin
            errors++;
            $display("FAIL reset_bank_untouched: bank=%h, required %h", bank_q, regm);
        end
    endtask

    task automatic test_single_load();
        obs_t o, e;
        time  t;
        model_txn(4'b0001, 8'h00, 32'h0000_00A5, e);
        txn(4'b0001, 8'h00, 32'h0000_00A5, 1, o, t);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL single_load: obs=%h, required %h", o, e);
        end
        checks++;
        if (o.load !== 1'b1 || o.d !== 8'hA5) begin
            errors++;
            $display("FAIL single_load_pulse: load=%b d=%h, required 1 a5", o.load, o.d);
        end
        model_txn(4'b0001, 8'h03, 32'h0, e);
        txn(4'b0001, 8'h03, 32'h0, 1, o, t);
        checks++;
        if (o !== e || o.rdata !== 8'hA5) begin
            errors++;
            $display("FAIL single_load_readback: obs=%h rdata=%h, required %h rdata=a5", o, o.rdata, e);
        end
    endtask

    task automatic test_preset_clear();
        obs_t o, e;
        time  t;
        logic [7:0] ops [4]  = '{8'h10, 8'h30, 8'h20, 8'h30};
        logic [7:0] rexp [4] = '{8'hA5, 8'hFF, 8'hFF, 8'h00};
        for (int n = 0; n < 4; n++) begin
            model_txn(4'b0100, ops[n], 32'h0, e);
            txn(4'b0100, ops[n], 32'h0, 1, o, t);
            checks++;
            if (o !== e || o.rdata !== rexp[n]) begin
                errors++;
                $display("FAIL preset_clear step %0d: obs=%h rdata=%h, required %h rdata=%h",
                         n, o, o.rdata, e, rexp[n]);
            end
        end
    endtask

    task automatic test_request_drop();
        obs_t o, e;
        time  t;
        model_txn(4'b1000, 8'h00, 32'h3C00_0000, e);
        txn(4'b1000, 8'h00, 32'h3C00_0000, 2, o, t);
        checks++;
        if (o !== e || o.ack_a !== 4'b1000) begin
            errors++;
            $display("FAIL request_drop: obs=%h ack=%b, required %h ack=1000", o, o.ack_a, e);
        end
        repeat (3) begin
            @(negedge Clk);
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL request_drop_no_retx: busy=%b, required 0", busy);
            end
        end
        model_txn(4'b1000, 8'hC0, 32'h0, e);
        txn(4'b1000, 8'hC0, 32'h0, 1, o, t);
        checks++;
        if (o !== e || o.rdata !== 8'h3C) begin
            errors++;
            $display("FAIL request_drop_readback: obs=%h rdata=%h, required %h rdata=3c", o, o.rdata, e);
        end
    endtask

    task automatic test_round_robin();
        obs_t o, e;
        time  t, tprev;
        int   seq [5] = '{0, 1, 2, 3, 0};
        logic [3:0] exp_oh;
        tprev = 0;
        for (int n = 0; n < 5; n++) begin
            model_txn(4'b1111, 8'hFF, 32'h0, e);
            txn(4'b1111, 8'hFF, 32'h0, (n == 4) ? 1 : 0, o, t);
            exp_oh = 4'b0001 << seq[n];
            checks++;
            if (o !== e || o.ack_a !== exp_oh) begin
                errors++;
                $display("FAIL round_robin step %0d: obs=%h ack=%b, required %h ack=%b",
                         n, o, o.ack_a, e, exp_oh);
            end
            if (n > 0) begin
                checks++;
                if (t - tprev != 30) begin
                    errors++;
                    $display("FAIL round_robin_spacing step %0d: %0t, required 30", n, t - tprev);
                end
            end
            tprev = t;
        end
    endtask

    task automatic test_priority_rotation();
        obs_t o, e;
        time  t;
        model_txn(4'b0010, 8'h0C, 32'h0, e);
        txn(4'b0010, 8'h0C, 32'h0, 1, o, t);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL priority_serve1: obs=%h, required %h", o, e);
        end
        model_txn(4'b0011, 8'h0F, 32'h0, e);
        txn(4'b0011, 8'h0F, 32'h0, 1, o, t);
        checks++;
        if (o !== e || o.gnt_e !== 4'b0001) begin
            errors++;
            $display("FAIL priority_rotation: obs=%h gnt=%b, required %h gnt=0001", o, o.gnt_e, e);
        end
    endtask

    task automatic test_random();
        obs_t        o, e;
        time         t;
        logic [3:0]  r;
        logic [7:0]  ops;
        logic [31:0] wd;
        for (int n = 0; n < 40; n++) begin
            r   = 4'($urandom_range(1, 15));
            ops = 8'($urandom);
            wd  = $urandom;
            model_txn(r, ops, wd, e);
            txn(r, ops, wd, int'($urandom_range(1, 2)), o, t);
            checks++;
            if (o !== e || bank_q !== regm) begin
                errors++;
                $display("FAIL random %0d req=%b op=%h: obs=%h bank=%h, required %h bank=%h",
                         n, r, ops, o, bank_q, e, regm);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_preset_clear();
        test_request_drop();
        test_round_robin();
        test_priority_rotation();
        test_random();
        inv_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
